sdfa_cfg_serializer: RTL and testbench
======================================

Name: sdfa_cfg_serializer

Overview:
- Configuration transmitter for the SDFA top controller's serial set-up port.
- A host writes 9 master config words (28 b), a 3-bit LAYER field and 9 block config words (19 b) into shadow registers.
- On start, it shifts the packed 255-bit master image onto master_in/master_inf_valid and the 171-bit block image onto block_in/block_inf_valid. Both streams are LSB-first and concurrent, gated by the controller's set_up_req.
- Bit i of each image is sent on the i-th valid cycle, matching the controller's valid-counted bit indexing.

Parameters:
- N_WORDS, 9, config words per stream.
- M_W, 28, master word width.
- B_W, 19, block word width.
- MASTER_BITS, 255, master image length (N_WORDS*M_W + 3 LAYER bits).
- BLOCK_BITS, 171, block image length (N_WORDS*B_W).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  shadow-register write strobe.
- cfg_sel  in  1  0 = master bank, 1 = block bank.
- cfg_addr  in  4  word index: master 0..8 words, 9 = LAYER; block 0..8.
- cfg_wdata  in  28  write data (block uses [18:0]; LAYER uses [2:0]).
- start  in  1  begin transmission (pulse or level).
- set_up_req  in  1  controller ready to accept set-up bits; gates shifting.
- master_in  out  1  serial master bit.
- master_inf_valid  out  1  master bit valid.
- block_in  out  1  serial block bit.
- block_inf_valid  out  1  block bit valid.
- busy  out  1  state == SHIFT.
- done  out  1  state == DONE.
- cfg_err  out  1  one-cycle pulse on a rejected write/start.

Behaviour:
- Reset (async, rstn low):
  - State IDLE; shadow images = 0; counters m_cnt = b_cnt = 0.
  - All outputs 0 immediately, including mid-transmission.
- Image packing:
  - Master image [28k+27:28k] = master word k (k = 0..8); [254:252] = LAYER.
  - Block image [19k+18:19k] = block word k.
- Writes:
  - Accepted only in IDLE; word replaced whole; unused wdata bits ignored.
  - Rejected with a cfg_err pulse next cycle, shadow unchanged, when:
    - addr > 9 (master) or addr > 8 (block);
    - cfg_we is high in SHIFT or DONE.
- State machine: IDLE, SHIFT, DONE.
  - IDLE -> SHIFT when start is sampled high.
  - A write in the same IDLE cycle as start is included in the transmitted image.
  - SHIFT -> DONE at the edge after both streams have issued their final bit.
  - DONE is terminal until rstn, because the controller's receive counters are free-running: one configuration per reset.
  - start in SHIFT is ignored silently; start in DONE produces a cfg_err pulse.
- Shifting (SHIFT state, all outputs registered):
  - On each edge with set_up_req = 1 and m_cnt < 255: master_inf_valid <= 1, master_in <= mimg[m_cnt], m_cnt += 1. Otherwise master_inf_valid <= 0 and master_in holds.
  - The block stream is identical with b_cnt < 171 and bimg.
  - The streams are independent; the block stream finishes first.
  - set_up_req low pauses both streams with no bit lost or repeated; they resume at the same index.
- Latency:
  - start sampled at edge E0; with set_up_req held high, valid is high after edges E1..E255 (master) and E1..E171 (block).
  - At E256: master_inf_valid = 0, state = DONE, done = 1, busy = 0.
- Counter widths:
  - m_cnt is 8 b and saturates at 255. It never wraps, because a 256th valid would overwrite master bit 0 at the receiver.
  - b_cnt is 8 b and saturates at 171.
- No valid is ever asserted outside SHIFT.

Test Plan:
- Reset, write master words k = 0x1000000+k, LAYER = 5, block words 0x40000+k, start, set_up_req = 1 -> exactly 255 master and 171 block valid cycles, contiguous from the cycle after start. A bench-side receiver reconstructs the images bit-exact, with LAYER bits [254:252] = 3'b101. done rises one cycle after the last master valid.
- Toggle set_up_req 1/0 every 3 cycles during SHIFT -> valid high only when gated; total counts still 255/171; reconstructed images unchanged.
- Write master addr 10, then block addr 9 -> cfg_err pulses twice; images unchanged (all zero after reset).
- cfg_we in SHIFT and start in DONE -> cfg_err pulses; image and state unaffected; no further valids.
- Assert rstn low at master bit 100 -> valids drop immediately; state IDLE; images cleared. Re-write and start -> full 255/171 transmission.
- cfg_we (master addr 0, data 0xABCDEF1) in the same cycle as start -> transmitted master bits [27:0] = 0xABCDEF1.

Source files
------------

// File: rtl/sdfa_cfg_serializer.sv
// Set-up port transmitter for the SDFA controller: holds master/block config words in shadow
// registers and streams the packed images LSB-first, one bit per set_up_req-gated cycle.
module sdfa_cfg_serializer #(
    parameter int unsigned N_WORDS     = 9,
    parameter int unsigned M_W         = 28,
    parameter int unsigned B_W         = 19,
    parameter int unsigned MASTER_BITS = 255,
    parameter int unsigned BLOCK_BITS  = 171
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           cfg_we,
    input  logic           cfg_sel,
    input  logic [3:0]     cfg_addr,
    input  logic [M_W-1:0] cfg_wdata,
    input  logic           start,
    input  logic           set_up_req,
    output logic           master_in,
    output logic           master_inf_valid,
    output logic           block_in,
    output logic           block_inf_valid,
    output logic           busy,
    output logic           done,
    output logic           cfg_err
);

    localparam logic [7:0] M_LAST = 8'(MASTER_BITS);
    localparam logic [7:0] B_LAST = 8'(BLOCK_BITS);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                r_state;
    logic [M_W-1:0]        r_mword [N_WORDS];
    logic [B_W-1:0]        r_bword [N_WORDS];
    logic [2:0]            r_layer;
    logic [7:0]            r_mcnt;
    logic [7:0]            r_bcnt;
    logic                  r_min;
    logic                  r_mval;
    logic                  r_bin;
    logic                  r_bval;
    logic                  r_err;

    logic [MASTER_BITS-1:0] w_mimg;
    logic [BLOCK_BITS-1:0]  w_bimg;
    logic                   w_addr_ok;
    logic                   w_wr;
    logic                   w_err;

    always_comb begin
        w_mimg = '0;
        w_bimg = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            w_mimg[k*M_W +: M_W] = r_mword[k];
            w_bimg[k*B_W +: B_W] = r_bword[k];
        end
        w_mimg[MASTER_BITS-1 -: 3] = r_layer;
    end

    // Master bank has an extra slot at address 9 for the LAYER field.
    assign w_addr_ok = cfg_sel ? (cfg_addr < 4'd9) : (cfg_addr < 4'd10);
    assign w_wr      = cfg_we && (r_state == StIdle) && w_addr_ok;
    assign w_err     = (cfg_we && ((r_state != StIdle) || !w_addr_ok)) ||
                       (start && (r_state == StDone));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
            for (int k = 0; k < N_WORDS; k++) begin
                r_mword[k] <= '0;
                r_bword[k] <= '0;
            end
            r_layer <= '0;
            r_mcnt  <= '0;
            r_bcnt  <= '0;
            r_min   <= 1'b0;
            r_mval  <= 1'b0;
            r_bin   <= 1'b0;
            r_bval  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_mval <= 1'b0;
            r_bval <= 1'b0;
            if (w_wr) begin
                if (cfg_sel) begin
                    r_bword[cfg_addr] <= cfg_wdata[B_W-1:0];
                end else if (cfg_addr == 4'd9) begin
                    r_layer <= cfg_wdata[2:0];
                end else begin
                    r_mword[cfg_addr] <= cfg_wdata;
                end
            end
            case (r_state)
                StIdle: begin
                    if (start) r_state <= StShift;
                end
                StShift: begin
                    // Counters stop at the image length; a further valid would
                    // overwrite bit 0 at the receiver.
                    if (set_up_req && (r_mcnt < M_LAST)) begin
                        r_mval <= 1'b1;
                        r_min  <= w_mimg[r_mcnt];
                        r_mcnt <= r_mcnt + 8'd1;
                    end
                    if (set_up_req && (r_bcnt < B_LAST)) begin
                        r_bval <= 1'b1;
                        r_bin  <= w_bimg[r_bcnt];
                        r_bcnt <= r_bcnt + 8'd1;
                    end
                    if ((r_mcnt == M_LAST) && (r_bcnt == B_LAST)) r_state <= StDone;
                end
                default: ;
            endcase
        end
    end

    assign master_in        = r_min;
    assign master_inf_valid = r_mval;
    assign block_in         = r_bin;
    assign block_inf_valid  = r_bval;
    assign cfg_err          = r_err;
    assign busy             = (r_state == StShift);
    assign done             = (r_state == StDone);

endmodule

// File: tb/tb_sdfa_cfg_serializer.sv
// Directed bench for sdfa_cfg_serializer: loads config words, receives both serial streams and
// compares reconstructed images, timing and error pulses against a bench-side packing model.
module tb_sdfa_cfg_serializer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cfg_we;
    logic        cfg_sel;
    logic [3:0]  cfg_addr;
    logic [27:0] cfg_wdata;
    logic        start;
    logic        set_up_req;
    logic        master_in;
    logic        master_inf_valid;
    logic        block_in;
    logic        block_inf_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;

    sdfa_cfg_serializer dut (
        .clk              (clk),
        .rstn             (rstn),
        .cfg_we           (cfg_we),
        .cfg_sel          (cfg_sel),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .start            (start),
        .set_up_req       (set_up_req),
        .master_in        (master_in),
        .master_inf_valid (master_inf_valid),
        .block_in         (block_in),
        .block_inf_valid  (block_inf_valid),
        .busy             (busy),
        .done             (done),
        .cfg_err          (cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference shadow contents
    logic [27:0] mw [9];
    logic [18:0] bw [9];
    logic [2:0]  lay;

    // Receiver results
    logic [255:0] rxm;
    logic [255:0] rxb;
    int mc, bc, m_first, m_last, b_first, b_last, done_n, viol;
    bit aborted;
    logic err_shift;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [254:0] exp_m();
        logic [254:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[28*k +: 28] = mw[k];
        v[254:252] = lay;
        return v;
    endfunction

    function automatic logic [170:0] exp_b();
        logic [170:0] v;
        v = '0;
        for (int k = 0; k < 9; k++) v[19*k +: 19] = bw[k];
        return v;
    endfunction

    task automatic do_reset();
        rstn = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; set_up_req = 1'b0;
        for (int k = 0; k < 9; k++) begin mw[k] = '0; bw[k] = '0; end
        lay = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [27:0] data,
                      output logic err);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_wdata = data;
        @(negedge clk);
        cfg_we = 1'b0;
        err = cfg_err;
    endtask

    task automatic load_all(input bit skip_m0);
        logic e;
        for (int k = 0; k < 9; k++) begin
            if (!(skip_m0 && k == 0)) begin
                mw[k] = 28'(32'h100_0000 + k);
                wr(1'b0, 4'(k), mw[k], e);
                check_eq("wr_master_err", e, 1'b0);
            end
            bw[k] = 19'(32'h4_0000 + k);
            wr(1'b1, 4'(k), 28'(bw[k]), e);
            check_eq("wr_block_err", e, 1'b0);
        end
        lay = 3'd5;
        wr(1'b0, 4'd9, 28'hFFFF_FFD, e);
        check_eq("wr_layer_err", e, 1'b0);
    endtask

    // Pulses start, then receives both streams one negedge per clock until done.
    task automatic tx(input bit toggle, input bit wr0, input logic [27:0] d0,
                      input bit wr_shift, input int abort_at);
        int n;
        logic sur;
        mc = 0; bc = 0; rxm = '0; rxb = '0; viol = 0; aborted = 1'b0; err_shift = 1'b0;
        m_first = -1; m_last = -1; b_first = -1; b_last = -1; done_n = -1;
        set_up_req = 1'b1;
        start = 1'b1;
        if (wr0) begin cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = d0; end
        @(negedge clk);
        start = 1'b0;
        cfg_we = 1'b0;
        n = 0;
        while (!done && n < 1500 && !aborted) begin
            if (toggle) set_up_req = ((n / 3) % 2) == 0;
            if (wr_shift && n == 0) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 4'd0; cfg_wdata = '1;
            end
            sur = set_up_req;
            @(negedge clk);
            n++;
            if (wr_shift && n == 1) begin cfg_we = 1'b0; err_shift = cfg_err; end
            if (master_inf_valid) begin
                if (mc < 256) rxm[mc] = master_in;
                if (m_first < 0) m_first = n;
                m_last = n;
                mc++;
            end
            if (block_inf_valid) begin
                if (bc < 256) rxb[bc] = block_in;
                if (b_first < 0) b_first = n;
                b_last = n;
                bc++;
            end
            if ((master_inf_valid || block_inf_valid) && (!busy || !sur)) viol++;
            if (abort_at != 0 && mc == abort_at) begin
                rstn = 1'b0;
                #1;
                aborted = 1'b1;
            end
        end
        set_up_req = 1'b1;
        if (done) done_n = n;
    endtask

    task automatic check_tx(input string p, input bit contiguous);
        check_eq({p, "_done"}, done, 1'b1);
        check_eq({p, "_busy"}, busy, 1'b0);
        check_eq({p, "_mcnt"}, 32'(mc), 32'd255);
        check_eq({p, "_bcnt"}, 32'(bc), 32'd171);
        check_eq({p, "_mimg"}, rxm, {1'b0, exp_m()});
        check_eq({p, "_bimg"}, rxb, {85'd0, exp_b()});
        check_eq({p, "_viol"}, 32'(viol), 32'd0);
        check_eq({p, "_done_lag"}, 32'(done_n - m_last), 32'd1);
        if (contiguous) begin
            check_eq({p, "_m_first"}, 32'(m_first), 32'd1);
            check_eq({p, "_m_last"}, 32'(m_last), 32'd255);
            check_eq({p, "_b_first"}, 32'(b_first), 32'd1);
            check_eq({p, "_b_last"}, 32'(b_last), 32'd171);
            check_eq({p, "_done_at"}, 32'(done_n), 32'd256);
        end
    endtask

    initial begin
        logic e;
        int extra;

        // Reset state
        rstn = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        start = 1'b0; set_up_req = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_mval", master_inf_valid, 1'b0);
        check_eq("rst_bval", block_inf_valid, 1'b0);
        check_eq("rst_err", cfg_err, 1'b0);

        // Full transmission, set_up_req held high
        do_reset();
        load_all(1'b0);
        tx(1'b0, 1'b0, '0, 1'b0, 0);
        check_tx("full", 1'b1);
        check_eq("full_layer", rxm[254:252], 3'b101);

        // set_up_req toggled every 3 cycles
        do_reset();
        load_all(1'b0);
        tx(1'b1, 1'b0, '0, 1'b0, 0);
        check_tx("gated", 1'b0);

        // Out-of-range addresses
        do_reset();
        wr(1'b0, 4'd10, 28'h123_4567, e);
        check_eq("bad_maddr_err", e, 1'b1);
        @(negedge clk);
        check_eq("err_pulse_low", cfg_err, 1'b0);
        wr(1'b1, 4'd9, 28'h7_FFFF, e);
        check_eq("bad_baddr_err", e, 1'b1);

        // Write during SHIFT rejected; images remain all zero
        tx(1'b0, 1'b0, '0, 1'b1, 0);
        check_eq("shift_wr_err", err_shift, 1'b1);
        check_tx("zero", 1'b1);

        // start in DONE: error pulse, no new transmission
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_start_err", cfg_err, 1'b1);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (master_inf_valid || block_inf_valid || busy) extra++;
        end
        check_eq("done_no_valid", 32'(extra), 32'd0);
        check_eq("done_hold", done, 1'b1);

        // Asynchronous reset mid-transmission
        do_reset();
        load_all(1'b0);
        tx(1'b0, 1'b0, '0, 1'b0, 100);
        check_eq("abort_hit", aborted, 1'b1);
        check_eq("abort_mval", master_inf_valid, 1'b0);
        check_eq("abort_bval", block_inf_valid, 1'b0);
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_done", done, 1'b0);
        // Master word 0 left unwritten: its bits must come out cleared
        do_reset();
        load_all(1'b1);
        tx(1'b0, 1'b0, '0, 1'b0, 0);
        check_tx("after_rst", 1'b1);

        // Write coincident with start lands in the image
        do_reset();
        load_all(1'b1);
        mw[0] = 28'hABC_DEF1;
        tx(1'b0, 1'b1, 28'hABC_DEF1, 1'b0, 0);
        check_eq("same_cyc_w0", rxm[27:0], 28'hABC_DEF1);
        check_tx("same_cyc", 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
